// File: rtl/decoder_if.sv
// Datapath control bundle driven by the instruction decoder.
// The decoder owns the master side; the datapath (or a model of it) takes the slave side.
interface decoder_if;
    logic       clear_carry;
    logic       write_carry;
    logic       clear_accumulator;
    logic       write_accumulator;
    logic       write_register;
    logic [3:0] inst_operand;
    logic [2:0] acc_input_sel;
    logic       reg_input_sel;
    logic [2:0] alu_op;
    logic [1:0] alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic [1:0] alu_cin_sel;

    modport master (
        output clear_carry, write_carry, clear_accumulator, write_accumulator,
               write_register, inst_operand, acc_input_sel, reg_input_sel,
               alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel
    );

    modport slave (
        input  clear_carry, write_carry, clear_accumulator, write_accumulator,
               write_register, inst_operand, acc_input_sel, reg_input_sel,
               alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel
    );
endinterface

// File: rtl/decoder.sv
// Instruction sequencer / decoder for the 4-bit core.
// Runs the 8-phase machine cycle (A1 A2 A3 M1 M2 X1 X2 X3), latches opr at the
// end of M1 and opa at the end of M2, and strobes the datapath in X1 only.
// Optional build macro: CTRL_HALT_EN adds the `halt` input, which parks the
// sequencer in A1 while asserted.
module decoder (
    input  logic       clock,
    input  logic       reset,
`ifdef CTRL_HALT_EN
    input  logic       halt,
`endif
    input  logic [3:0] data_in,
    output logic       sync,
    output logic [2:0] cycle,
    output logic       second_word,
    output logic       illegal,
    decoder_if.master  dp
);
    // Phase numbering
    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X3 = 3'd7;

    // Datapath select encodings
    localparam logic [2:0] ACC_SEL_ALU    = 3'd0;
    localparam logic [2:0] ACC_SEL_REG    = 3'd1;
    localparam logic [2:0] ACC_SEL_IMM    = 3'd2;
    localparam logic [2:0] ACC_SEL_CARRY  = 3'd3;
    localparam logic [2:0] ACC_SEL_CARRY2 = 3'd4;
    localparam logic       REG_SEL_ALU    = 1'b0;
    localparam logic       REG_SEL_ACC    = 1'b1;
    localparam logic [2:0] ALU_OP_ADD     = 3'd0;
    localparam logic [1:0] ALU_IN_ZERO    = 2'd0;
    localparam logic [1:0] ALU_IN_ACC     = 2'd1;
    localparam logic [1:0] ALU_IN_REG     = 2'd2;
    localparam logic [1:0] ALU_IN_REG_N   = 2'd3;
    localparam logic [1:0] ALU_CIN_ZERO   = 2'd0;
    localparam logic [1:0] ALU_CIN_ONE    = 2'd1;
    localparam logic [1:0] ALU_CIN_CARRY  = 2'd2;
    localparam logic [1:0] ALU_CIN_CARRY_N = 2'd3;

    logic [2:0] r_cycle;
    logic [2:0] w_cycle_next;
    logic [3:0] r_opr;
    logic [3:0] r_opa;
    logic       r_second_word;

    logic       w_two_word;
    logic       w_bad_op;
    logic       w_fire;
    logic       w_clr_c, w_wr_c, w_clr_a, w_wr_a, w_wr_r;
    logic [2:0] w_acc_sel;
    logic       w_reg_sel;
    logic [1:0] w_in0_sel, w_in1_sel, w_cin_sel;

    // Next phase: free-running wrap, optionally parked in A1 by halt
    always_comb begin
        w_cycle_next = r_cycle + 3'd1;
`ifdef CTRL_HALT_EN
        if (r_cycle == PH_A1 && halt) begin
            w_cycle_next = PH_A1;
        end
`endif
    end

    // Phase, opcode latches and two-word tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle       <= PH_A1;
            r_opr         <= 4'h0;
            r_opa         <= 4'h0;
            r_second_word <= 1'b0;
        end else begin
            r_cycle <= w_cycle_next;
            if (r_cycle == PH_M1) r_opr <= data_in;
            if (r_cycle == PH_M2) r_opa <= data_in;
            // A second word never starts another two-word sequence
            if (r_cycle == PH_X3) r_second_word <= ~r_second_word & w_two_word;
        end
    end

    // Opcode decode into strobe intents and datapath selects
    always_comb begin
        w_two_word = 1'b0;
        w_bad_op   = 1'b0;
        w_clr_c    = 1'b0;
        w_wr_c     = 1'b0;
        w_clr_a    = 1'b0;
        w_wr_a     = 1'b0;
        w_wr_r     = 1'b0;
        w_acc_sel  = ACC_SEL_ALU;
        w_reg_sel  = REG_SEL_ALU;
        w_in0_sel  = ALU_IN_ZERO;
        w_in1_sel  = ALU_IN_ZERO;
        w_cin_sel  = ALU_CIN_ZERO;
        case (r_opr)
            4'h0: begin end
            4'h1, 4'h4, 4'h5, 4'h7: w_two_word = 1'b1;
            4'h2: begin
                if (r_opa[0]) w_bad_op   = 1'b1;
                else          w_two_word = 1'b1;
            end
            4'h6: begin
                w_in0_sel = ALU_IN_REG;
                w_in1_sel = ALU_IN_ZERO;
                w_cin_sel = ALU_CIN_ONE;
                w_reg_sel = REG_SEL_ALU;
                w_wr_r    = 1'b1;
            end
            4'h8: begin
                w_in0_sel = ALU_IN_ACC;
                w_in1_sel = ALU_IN_REG;
                w_cin_sel = ALU_CIN_CARRY;
                w_acc_sel = ACC_SEL_ALU;
                w_wr_a    = 1'b1;
                w_wr_c    = 1'b1;
            end
            4'h9: begin
                w_in0_sel = ALU_IN_ACC;
                w_in1_sel = ALU_IN_REG_N;
                w_cin_sel = ALU_CIN_CARRY_N;
                w_acc_sel = ACC_SEL_ALU;
                w_wr_a    = 1'b1;
                w_wr_c    = 1'b1;
            end
            4'hA: begin
                w_acc_sel = ACC_SEL_REG;
                w_wr_a    = 1'b1;
            end
            4'hB: begin
                w_acc_sel = ACC_SEL_REG;
                w_reg_sel = REG_SEL_ACC;
                w_wr_a    = 1'b1;
                w_wr_r    = 1'b1;
            end
            4'hD: begin
                w_acc_sel = ACC_SEL_IMM;
                w_wr_a    = 1'b1;
            end
            4'hF: begin
                case (r_opa)
                    4'h0: begin
                        w_clr_a = 1'b1;
                        w_clr_c = 1'b1;
                    end
                    4'h1: w_clr_c = 1'b1;
                    4'h2: begin
                        w_in0_sel = ALU_IN_ACC;
                        w_in1_sel = ALU_IN_ZERO;
                        w_cin_sel = ALU_CIN_ONE;
                        w_acc_sel = ACC_SEL_ALU;
                        w_wr_a    = 1'b1;
                        w_wr_c    = 1'b1;
                    end
                    // Accumulator takes the carry as it stood before this clear
                    4'h7: begin
                        w_acc_sel = ACC_SEL_CARRY;
                        w_wr_a    = 1'b1;
                        w_clr_c   = 1'b1;
                    end
                    4'h9: begin
                        w_acc_sel = ACC_SEL_CARRY2;
                        w_wr_a    = 1'b1;
                        w_clr_c   = 1'b1;
                    end
                    default: w_bad_op = 1'b1;
                endcase
            end
            default: w_bad_op = 1'b1;
        endcase
    end

    // Outputs: strobes fire for one clock in X1 of a first (or only) word
    always_comb begin
        w_fire                = (r_cycle == PH_X1) && !r_second_word && !reset;
        sync                  = (r_cycle == PH_A1);
        cycle                 = r_cycle;
        second_word           = r_second_word;
        illegal               = w_fire & w_bad_op;
        dp.clear_carry        = w_fire & w_clr_c;
        dp.write_carry        = w_fire & w_wr_c;
        dp.clear_accumulator  = w_fire & w_clr_a;
        dp.write_accumulator  = w_fire & w_wr_a;
        dp.write_register     = w_fire & w_wr_r;
        dp.inst_operand       = r_opa;
        dp.acc_input_sel      = w_acc_sel;
        dp.reg_input_sel      = w_reg_sel;
        dp.alu_op             = ALU_OP_ADD;
        dp.alu_in0_sel        = w_in0_sel;
        dp.alu_in1_sel        = w_in1_sel;
        dp.alu_cin_sel        = w_cin_sel;
    end
endmodule

// File: tb/tb_decoder.sv
// Testbench for decoder: directed test-plan steps followed by random
// instruction streams. A small datapath model consumes the DUT's controls and
// its architectural state is compared with an instruction-level reference.
module tb_decoder;
    localparam logic [2:0] ACC_SEL_ALU    = 3'd0;
    localparam logic [2:0] ACC_SEL_REG    = 3'd1;
    localparam logic [2:0] ACC_SEL_IMM    = 3'd2;
    localparam logic [2:0] ACC_SEL_CARRY  = 3'd3;
    localparam logic [2:0] ACC_SEL_CARRY2 = 3'd4;
    localparam logic [2:0] ALU_OP_ADD     = 3'd0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data_in = 4'h0;
`ifdef CTRL_HALT_EN
    logic       halt = 1'b0;
`endif
    logic       sync;
    logic [2:0] cycle;
    logic       second_word;
    logic       illegal;

    decoder_if dp ();

    decoder dut (
        .clock       (clock),
        .reset       (reset),
`ifdef CTRL_HALT_EN
        .halt        (halt),
`endif
        .data_in     (data_in),
        .sync        (sync),
        .cycle       (cycle),
        .second_word (second_word),
        .illegal     (illegal),
        .dp          (dp)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Architectural state: reference (instruction level) and datapath model
    logic [3:0]       ref_acc, dp_acc;
    logic             ref_c, dp_c;
    logic [15:0][3:0] ref_r, dp_r;
    logic             cur_sw;
    logic [3:0]       op_tab [0:17];
    logic [3:0]       f_tab [0:5];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_two_word(input logic [3:0] o, input logic [3:0] a);
        return (o == 4'h1) || (o == 4'h4) || (o == 4'h5) || (o == 4'h7) ||
               (o == 4'h2 && !a[0]);
    endfunction

    // Expected X1 controls {illegal, clr_acc, clr_c, wr_acc, wr_c, wr_reg}
    function automatic logic [5:0] exp_ctl(input logic [3:0] o, input logic [3:0] a);
        case (o)
            4'h0, 4'h1, 4'h4, 4'h5, 4'h7: return 6'b000000;
            4'h2: return a[0] ? 6'b100000 : 6'b000000;
            4'h6: return 6'b000001;
            4'h8, 4'h9: return 6'b000110;
            4'hA, 4'hD: return 6'b000100;
            4'hB: return 6'b000101;
            4'hF: begin
                case (a)
                    4'h0: return 6'b011000;
                    4'h1: return 6'b001000;
                    4'h2: return 6'b000110;
                    4'h7, 4'h9: return 6'b001100;
                    default: return 6'b100000;
                endcase
            end
            default: return 6'b100000;
        endcase
    endfunction

    function automatic logic [2:0] exp_acc_sel(input logic [3:0] o, input logic [3:0] a);
        case (o)
            4'hA, 4'hB: return ACC_SEL_REG;
            4'hD: return ACC_SEL_IMM;
            4'hF: return (a == 4'h7) ? ACC_SEL_CARRY : (a == 4'h9) ? ACC_SEL_CARRY2 : ACC_SEL_ALU;
            default: return ACC_SEL_ALU;
        endcase
    endfunction

    // Instruction-level semantics with plain arithmetic
    task automatic ref_exec(input logic [3:0] o, input logic [3:0] a);
        int t;
        logic [3:0] tmp;
        case (o)
            4'h6: ref_r[a] = 4'((int'(ref_r[a]) + 1) % 16);
            4'h8: begin
                t = int'(ref_acc) + int'(ref_r[a]) + int'(ref_c);
                ref_acc = 4'(t % 16); ref_c = (t >= 16);
            end
            4'h9: begin
                t = int'(ref_acc) + (15 - int'(ref_r[a])) + (1 - int'(ref_c));
                ref_acc = 4'(t % 16); ref_c = (t >= 16);
            end
            4'hA: ref_acc = ref_r[a];
            4'hB: begin tmp = ref_acc; ref_acc = ref_r[a]; ref_r[a] = tmp; end
            4'hD: ref_acc = a;
            4'hF: begin
                case (a)
                    4'h0: begin ref_acc = 4'h0; ref_c = 1'b0; end
                    4'h1: ref_c = 1'b0;
                    4'h2: begin
                        t = int'(ref_acc) + 1;
                        ref_acc = 4'(t % 16); ref_c = (t >= 16);
                    end
                    4'h7: begin ref_acc = ref_c ? 4'd1 : 4'd0; ref_c = 1'b0; end
                    4'h9: begin ref_acc = ref_c ? 4'd10 : 4'd9; ref_c = 1'b0; end
                    default: begin end
                endcase
            end
            default: begin end
        endcase
    endtask

    function automatic logic [3:0] alu_operand(input logic [1:0] sel, input logic [3:0] acc, input logic [3:0] r);
        case (sel)
            2'd1: return acc;
            2'd2: return r;
            2'd3: return ~r;
            default: return 4'h0;
        endcase
    endfunction

    // Datapath model: acts on whatever the DUT drives during X1 (clear beats write)
    task automatic dp_apply();
        logic [3:0] ra, v0, v1, acc_in, nacc;
        logic       ci, nc;
        logic [4:0] sum;
        ra = dp_r[dp.inst_operand];
        v0 = alu_operand(dp.alu_in0_sel, dp_acc, ra);
        v1 = alu_operand(dp.alu_in1_sel, dp_acc, ra);
        case (dp.alu_cin_sel)
            2'd1: ci = 1'b1;
            2'd2: ci = dp_c;
            2'd3: ci = ~dp_c;
            default: ci = 1'b0;
        endcase
        sum = {1'b0, v0} + {1'b0, v1} + {4'b0, ci};
        case (dp.acc_input_sel)
            ACC_SEL_REG:    acc_in = ra;
            ACC_SEL_IMM:    acc_in = dp.inst_operand;
            ACC_SEL_CARRY:  acc_in = {3'b000, dp_c};
            ACC_SEL_CARRY2: acc_in = dp_c ? 4'd10 : 4'd9;
            default:        acc_in = sum[3:0];
        endcase
        nacc = dp_acc;
        nc   = dp_c;
        if (dp.write_carry)       nc = sum[4];
        if (dp.clear_carry)       nc = 1'b0;
        if (dp.write_accumulator) nacc = acc_in;
        if (dp.clear_accumulator) nacc = 4'h0;
        if (dp.write_register)
            dp_r[dp.inst_operand] = dp.reg_input_sel ? dp_acc : sum[3:0];
        dp_acc = nacc;
        dp_c   = nc;
    endtask

    // Run phases 0..n-1 of one machine cycle starting at an A1 negedge
    task automatic run_instr(input logic [3:0] o, input logic [3:0] a, input int n);
        logic [5:0] e;
        e = cur_sw ? 6'b000000 : exp_ctl(o, a);
        for (int p = 0; p < n; p++) begin
            check("cycle", 64'(cycle), 64'(p));
            check("sync", 64'(sync), 64'(p == 0));
            check("second_word", 64'(second_word), 64'(cur_sw));
            if (p == 5) begin
                check("x1_controls", 64'({illegal, dp.clear_accumulator, dp.clear_carry,
                      dp.write_accumulator, dp.write_carry, dp.write_register}), 64'(e));
                check("inst_operand", 64'(dp.inst_operand), 64'(a));
                check("alu_op", 64'(dp.alu_op), 64'(ALU_OP_ADD));
                if (e[2]) check("acc_input_sel", 64'(dp.acc_input_sel), 64'(exp_acc_sel(o, a)));
                dp_apply();
            end else begin
                check("idle_controls", 64'({illegal, dp.clear_accumulator, dp.clear_carry,
                      dp.write_accumulator, dp.write_carry, dp.write_register}), 64'(0));
            end
            data_in = (p == 3) ? o : (p == 4) ? a : 4'($urandom);
            @(negedge clock);
        end
        if (n == 8) begin
            if (!cur_sw) ref_exec(o, a);
            $display("instr opr=%h opa=%h sw=%0d acc=%h carry=%0d", o, a, cur_sw, ref_acc, ref_c);
            cur_sw = !cur_sw && is_two_word(o, a);
            check("acc", 64'(dp_acc), 64'(ref_acc));
            check("carry", 64'(dp_c), 64'(ref_c));
            check("regs", 64'(dp_r), 64'(ref_r));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cur_sw = 1'b0;
        check("reset_cycle", 64'(cycle), 64'(0));
        check("reset_sync", 64'(sync), 64'(1));
        check("reset_second_word", 64'(second_word), 64'(0));
        check("reset_operand", 64'(dp.inst_operand), 64'(0));
    endtask

    initial begin
        logic [3:0] o, a;
        op_tab = '{4'h0, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hF, 4'hF,
                   4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hC, 4'hE};
        f_tab  = '{4'h0, 4'h1, 4'h2, 4'h7, 4'h9, 4'h5};
        ref_acc = 4'h0; dp_acc = 4'h0;
        ref_c = 1'b0;   dp_c = 1'b0;
        ref_r = '0;     dp_r = '0;
        cur_sw = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset asserted in X2, then a full NOP cycle with no strobes
        run_instr(4'h0, 4'h0, 6);
        do_reset();
        run_instr(4'h0, 4'h0, 8);

        // LDM aborted by reset in M2: nothing may reach the datapath
        run_instr(4'hD, 4'h7, 4);
        do_reset();
        run_instr(4'h0, 4'h0, 8);
        check("abort_acc", 64'(dp_acc), 64'(0));

        // LDM 5, LD r3
        run_instr(4'hD, 4'h5, 8);
        check("ldm5_acc", 64'(dp_acc), 64'(5));
        run_instr(4'hA, 4'h3, 8);
        check("ld_r3_acc", 64'(dp_acc), 64'(0));

        // acc=9, carry=1, r2=7 then ADD r2
        run_instr(4'hD, 4'h7, 8);
        run_instr(4'hB, 4'h2, 8);
        run_instr(4'hD, 4'hF, 8);
        run_instr(4'hF, 4'h2, 8);
        run_instr(4'hD, 4'h9, 8);
        run_instr(4'h8, 4'h2, 8);
        check("add_acc", 64'(dp_acc), 64'(1));
        check("add_carry", 64'(dp_c), 64'(1));

        // JUN: two-word, no strobes, second_word for the second cycle only
        run_instr(4'h4, 4'h0, 8);
        check("jun_second_pending", 64'(second_word), 64'(1));
        run_instr(4'h1, 4'h2, 8);
        check("jun_second_done", 64'(second_word), 64'(0));

        // CLB with carry=1, acc=6; then an unimplemented F op
        run_instr(4'hD, 4'hF, 8);
        run_instr(4'hF, 4'h2, 8);
        run_instr(4'hD, 4'h6, 8);
        run_instr(4'hF, 4'h0, 8);
        check("clb_acc", 64'(dp_acc), 64'(0));
        check("clb_carry", 64'(dp_c), 64'(0));
        run_instr(4'hF, 4'h5, 8);

        // Random instruction stream
        for (int k = 0; k < 300; k++) begin
            o = op_tab[$urandom_range(0, 17)];
            a = 4'($urandom);
            if (o == 4'hF && $urandom_range(0, 3) != 0) a = f_tab[$urandom_range(0, 5)];
            run_instr(o, a, 8);
        end

`ifdef CTRL_HALT_EN
        begin
            int exp_ph;
            run_instr(4'h0, 4'h0, 5);
            data_in = 4'h0;
            halt = 1'b1;
            exp_ph = 5;
            for (int k = 0; k < 20; k++) begin
                check("halt_cycle", 64'(cycle), 64'(exp_ph));
                check("halt_sync", 64'(sync), 64'(exp_ph == 0));
                check("halt_controls", 64'({illegal, dp.clear_accumulator, dp.clear_carry,
                      dp.write_accumulator, dp.write_carry, dp.write_register}), 64'(0));
                @(negedge clock);
                exp_ph = (exp_ph == 0) ? 0 : (exp_ph + 1) % 8;
            end
            halt = 1'b0;
            check("halt_release_a1", 64'(cycle), 64'(0));
            @(negedge clock);
            check("halt_release_a2", 64'(cycle), 64'(1));
            $display("halt held 20 clocks, released into A2");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
